// File: rtl/pool_row_buffer_pkg.sv
// Shared definitions for the pooled-row datapath.
// Provides the element width, row/map geometry, counter widths and the
// packed pooled-row vector type common to the pool stage and the row buffer.
// No ports (package).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package pool_row_buffer_pkg;
  localparam int DATA_WIDTH   = `DATA_WIDTH;
  localparam int ROW_LEN      = 13;
  localparam int ROWS_PER_MAP = 13;
  localparam int COL_W        = $clog2(ROW_LEN);
  localparam int MAP_W        = $clog2(ROWS_PER_MAP);

  // Element 0 (leftmost column) sits in the lowest slice.
  typedef logic [ROW_LEN-1:0][DATA_WIDTH-1:0] pooled_row_t;
endpackage

// File: rtl/pool_row_buffer_row_fifo_mem.sv
// row_fifo_mem: DEPTH slots, each holding one whole pooled row.
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write the whole row into slot wr_addr
//   wr_addr  in   slot to write
//   wr_row   in   pooled row to store
//   rd_addr  in   slot to read
//   rd_col   in   column within the slot to read
//   rd_data  out  selected element (combinational)
module row_fifo_mem
  import pool_row_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  pooled_row_t           wr_row,
  input  logic [AW-1:0]         rd_addr,
  input  logic [COL_W-1:0]      rd_col,
  output logic [DATA_WIDTH-1:0] rd_data
);

  pooled_row_t mem [DEPTH];

  // Row storage: written whole, never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_row;
    end else begin
      mem[wr_addr] <= mem[wr_addr];
    end
  end

  // Element select; column codes past the row end read as zero.
  always_comb begin
    rd_data = {DATA_WIDTH{1'b0}};
    if (rd_col < COL_W'(ROW_LEN)) begin
      rd_data = mem[rd_addr][rd_col];
    end else begin
      rd_data = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/pool_row_buffer.sv
// pool_row_buffer: captures completed pooled rows on the rising edge of
// row_done, queues them in a DEPTH-row FIFO and streams them out one element
// per beat with row-end / map-end tags.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   row_in, row_done    pooled row and level done flag from the pool stage
//   row_ready           a slot is free
//   m_data/m_valid/m_ready  output stream
//   m_last_col          beat is the last column of a row
//   m_last_map          beat is the last column of the last row of a map
//   map_done            one-cycle pulse after the m_last_map beat transfers
//   overflow            sticky: a row was dropped because the FIFO was full
//   occupancy           rows currently held
module pool_row_buffer
  import pool_row_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pooled_row_t           row_in,
  input  logic                  row_done,
  output logic                  row_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last_col,
  output logic                  m_last_map,
  output logic                  map_done,
  output logic                  overflow,
  output logic [OW-1:0]         occupancy
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [MAP_W-1:0] MAP_LAST = MAP_W'(ROWS_PER_MAP - 1);
  localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);

  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [OW-1:0]         occ_r;
  logic [COL_W-1:0]      col_r;
  logic [MAP_W-1:0]      map_row_r;
  logic                  done_q_r;
  logic                  overflow_r;
  logic                  map_done_r;

  logic                  valid_s;
  logic                  push_s;
  logic                  xfer_s;
  logic                  last_col_s;
  logic                  last_row_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  accept_s;
  logic                  drop_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  row_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (accept_s),
    .wr_addr (wr_ptr_r),
    .wr_row  (row_in),
    .rd_addr (rd_ptr_r),
    .rd_col  (col_r),
    .rd_data (rd_data_s)
  );

  // Handshake decode. A push that meets the head row's final beat is taken
  // even when full, because that beat frees a slot in the same edge.
  always_comb begin
    valid_s    = (occ_r != {OW{1'b0}});
    push_s     = row_done & ~done_q_r;
    xfer_s     = valid_s & m_ready;
    last_col_s = (col_r == COL_LAST);
    last_row_s = (map_row_r == MAP_LAST);
    pop_s      = xfer_s & last_col_s;
    full_s     = (occ_r == OCC_FULL);
    accept_s   = push_s & (~full_s | pop_s);
    drop_s     = push_s & full_s & ~pop_s;
  end

  // Output drive; tags and data are forced low when nothing is held.
  always_comb begin
    m_valid    = valid_s;
    m_data     = valid_s ? rd_data_s : {DATA_WIDTH{1'b0}};
    m_last_col = valid_s & last_col_s;
    m_last_map = valid_s & last_col_s & last_row_s;
    row_ready  = ~full_s;
    map_done   = map_done_r;
    overflow   = overflow_r;
    occupancy  = occ_r;
  end

  // Pointers, counters, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      occ_r      <= {OW{1'b0}};
      col_r      <= {COL_W{1'b0}};
      map_row_r  <= {MAP_W{1'b0}};
      done_q_r   <= 1'b0;
      overflow_r <= 1'b0;
      map_done_r <= 1'b0;
    end else begin
      done_q_r   <= row_done;
      map_done_r <= pop_s & last_row_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (xfer_s) begin
        if (last_col_s) begin
          col_r     <= {COL_W{1'b0}};
          rd_ptr_r  <= rd_ptr_r + AW'(1);
          map_row_r <= last_row_s ? {MAP_W{1'b0}} : map_row_r + MAP_W'(1);
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end
      case ({accept_s, pop_s})
        2'b10:   occ_r <= occ_r + OW'(1);
        2'b01:   occ_r <= occ_r - OW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_row_buffer.sv
// Self-checking bench for pool_row_buffer: directed scenarios followed by a
// randomized phase, all checked against a queue-of-rows reference model.
module tb_pool_row_buffer;
  import pool_row_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  pooled_row_t           row_in;
  logic                  row_done;
  logic                  row_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last_col;
  logic                  m_last_map;
  logic                  map_done;
  logic                  overflow;
  logic [$clog2(DEPTH):0] occupancy;

  int checks   = 0;
  int failures = 0;

  // Reference model: rows held, position in head row, row-in-map, flags.
  pooled_row_t q[$];
  int          mcol = 0;
  int          mrow = 0;
  bit          movf = 1'b0;
  bit          mdq  = 1'b0;
  bit          mmd  = 1'b0;

  // Observed beats, for directed sequence checks.
  logic [DATA_WIDTH-1:0] got[$];
  bit                    got_lc[$];
  bit                    got_lm[$];
  int                    map_done_seen = 0;

  pool_row_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .row_done   (row_done),
    .row_ready  (row_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last_col (m_last_col),
    .m_last_map (m_last_map),
    .map_done   (map_done),
    .overflow   (overflow),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pooled_row_t mk_row(input int base);
    pooled_row_t r;
    for (int j = 0; j < ROW_LEN; j++) r[j] = DATA_WIDTH'(base + j);
    return r;
  endfunction

  function automatic pooled_row_t rand_row();
    pooled_row_t r;
    for (int j = 0; j < ROW_LEN; j++) r[j] = DATA_WIDTH'($urandom);
    return r;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic cycle(input bit r, input bit d, input bit rdy, input pooled_row_t row);
    bit v;
    bit push;
    bit lastc;
    logic [DATA_WIDTH-1:0] e_data;
    rst = r; row_done = d; m_ready = rdy; row_in = row;
    #1;
    v     = (q.size() != 0);
    lastc = v && (mcol == ROW_LEN - 1);
    if (v) e_data = q[0][mcol];
    else   e_data = '0;
    chk("m_valid",    m_valid,    v);
    chk("m_data",     m_data,     e_data);
    chk("m_last_col", m_last_col, lastc);
    chk("m_last_map", m_last_map, lastc && (mrow == ROWS_PER_MAP - 1));
    chk("map_done",   map_done,   mmd);
    chk("overflow",   overflow,   movf);
    chk("occupancy",  occupancy,  q.size());
    chk("row_ready",  row_ready,  q.size() < DEPTH);
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      got_lc.push_back(m_last_col);
      got_lm.push_back(m_last_map);
    end
    if (map_done) map_done_seen++;
    @(posedge clk);
    if (r) begin
      q.delete(); mcol = 0; mrow = 0; movf = 0; mdq = 0; mmd = 0;
    end else begin
      push = d && !mdq;
      mdq  = d;
      mmd  = 0;
      if (v && rdy) begin
        if (mcol == ROW_LEN - 1) begin
          void'(q.pop_front());
          mcol = 0;
          mmd  = (mrow == ROWS_PER_MAP - 1);
          mrow = mmd ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end
      if (push) begin
        if (q.size() < DEPTH) q.push_back(row);
        else movf = 1;
      end
    end
    #1;
  endtask

  task automatic clear_obs();
    got.delete(); got_lc.delete(); got_lm.delete(); map_done_seen = 0;
  endtask

  initial begin
    pooled_row_t zr;
    pooled_row_t r;
    int n;
    zr = '0;
    rst = 1'b1; row_done = 1'b0; m_ready = 1'b0; row_in = '0;
    @(posedge clk); #1;
    cycle(1, 0, 0, zr);
    cycle(0, 0, 1, zr);
    chk("reset_valid", m_valid, 1'b0);
    chk("reset_ready", row_ready, 1'b1);

    // Single row, done held high for 20 cycles.
    clear_obs();
    r = mk_row(1);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1, r);
    for (int i = 0; i < 3; i++)  cycle(0, 0, 1, r);
    chk("single_count", got.size(), 13);
    for (int i = 0; i < got.size(); i++) begin
      chk("single_data", got[i], i + 1);
      chk("single_lastcol", got_lc[i], i == 12);
    end
    chk("single_ovf", overflow, 1'b0);

    // Backpressure with ready pattern 1,0,0.
    clear_obs();
    r = mk_row(10);
    cycle(0, 1, 0, r);
    for (int i = 0; i < 45; i++) cycle(0, 0, (i % 3) == 0, r);
    chk("bp_count", got.size(), 13);
    for (int i = 0; i < got.size(); i++) chk("bp_data", got[i], 10 + i);

    // Overflow: five rows with no drain.
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 1, 0, mk_row(16 * k));
      cycle(0, 0, 0, mk_row(16 * k));
    end
    chk("ovf_occ", occupancy, 4);
    chk("ovf_ready", row_ready, 1'b0);
    chk("ovf_flag", overflow, 1'b1);
    clear_obs();
    for (int i = 0; i < 60; i++) cycle(0, 0, 1, zr);
    chk("ovf_count", got.size(), 52);
    for (int k = 1; k <= 4; k++)
      for (int j = 0; j < ROW_LEN; j++)
        if ((k - 1) * 13 + j < got.size())
          chk("ovf_data", got[(k - 1) * 13 + j], DATA_WIDTH'(16 * k + j));
    cycle(1, 0, 0, zr);

    // Full boundary: push coincides with head row's final beat.
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 1, 0, mk_row(20 * k));
      cycle(0, 0, 0, mk_row(20 * k));
    end
    for (int i = 0; i < 12; i++) cycle(0, 0, 1, zr);
    cycle(0, 1, 1, mk_row(100));
    cycle(0, 0, 0, zr);
    chk("bnd_occ", occupancy, 4);
    chk("bnd_ovf", overflow, 1'b0);
    for (int i = 0; i < 60; i++) cycle(0, 0, 1, zr);

    // Map wrap over 14 rows.
    cycle(1, 0, 0, zr);
    clear_obs();
    for (int k = 0; k < 14; k++) begin
      r = rand_row();
      cycle(0, 1, 1, r);
      for (int i = 0; i < 12; i++) cycle(0, 0, 1, r);
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, zr);
    chk("map_count", got.size(), 182);
    n = 0;
    for (int i = 0; i < got_lm.size(); i++) if (got_lm[i]) n++;
    chk("map_lastmap_n", n, 1);
    if (got_lm.size() > 168) chk("map_lastmap_pos", got_lm[168], 1'b1);
    chk("map_done_n", map_done_seen, 1);

    // Reset mid-row with two rows held.
    cycle(0, 1, 0, mk_row(50));
    cycle(0, 0, 0, zr);
    cycle(0, 1, 0, mk_row(70));
    cycle(0, 0, 0, zr);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, zr);
    cycle(1, 0, 1, zr);
    chk("mid_valid", m_valid, 1'b0);
    chk("mid_occ", occupancy, 0);
    clear_obs();
    cycle(0, 1, 1, mk_row(64));
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, zr);
    chk("mid_count", got.size(), 13);
    if (got.size() > 0) chk("mid_first", got[0], 64);

    // Randomized phase.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom % 300) == 0, ($urandom % 4) == 0, ($urandom % 3) != 0, rand_row());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_row_buffer.md
Name: pool_row_buffer

Overview:
- Downstream neighbour of the quantize/ReLU/2x2 max-pool stage. Captures each completed 13-element pooled row when that stage raises done.
- Holds captured rows in a small row FIFO. Serialises them one element per beat onto a valid/ready stream for the next layer.
- Tags row-end and feature-map-end beats, and flags rows lost to overflow.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (shared define), width of one pooled element.
- ROW_LEN, 13, elements per pooled row.
- DEPTH, 4, row slots in the FIFO (power of two, >=2).
- ROWS_PER_MAP, 13, pooled rows per output feature map.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- row_in  in  ROW_LEN x DATA_WIDTH  pooled row from the pool stage; element 0 is the leftmost column.
- row_done  in  1  pool stage done; level signal that stays high after the row is ready.
- row_ready  out  1  high when at least one slot is free; upstream uses it to gate its enable.
- m_data  out  DATA_WIDTH  current output element.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts the beat.
- m_last_col  out  1  beat is column ROW_LEN-1.
- m_last_map  out  1  beat is the last column of row ROWS_PER_MAP-1.
- map_done  out  1  one-cycle pulse, registered, in the cycle after the m_last_map beat transfers.
- overflow  out  1  sticky; set when a row is dropped.
- occupancy  out  clog2(DEPTH)+1  number of rows held.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - Clears the write/read pointers, occupancy, column counter, map-row counter, overflow, map_done, and the done-edge register.
  - Outputs after reset: m_valid=0, m_data=0, m_last_col=0, m_last_map=0, map_done=0, overflow=0, occupancy=0, row_ready=1.
  - Row storage is not required to clear.
  - Reset mid-stream discards all held rows and any partially sent row.
- Capture:
  - done_q registers row_done.
  - A push is a rising edge: row_done & ~done_q. A level held high must not push twice.
  - On a push the whole row_in vector is written into slot wr_ptr, wr_ptr advances (wraps modulo DEPTH), and occupancy increments.
- Full:
  - A push while occupancy==DEPTH is dropped and sets overflow.
  - Exception: if the final beat of the head row transfers in the same cycle, the push is accepted and occupancy stays at DEPTH.
- Output:
  - m_valid = (occupancy != 0).
  - m_data = slot[rd_ptr][col].
  - A beat transfers when m_valid & m_ready.
  - Each transfer increments col. At col==ROW_LEN-1 the transfer sets col to 0, advances rd_ptr, decrements occupancy and advances the map-row counter.
  - The map-row counter wraps at ROWS_PER_MAP-1.
- Latency: a row pushed at edge E is presented (m_valid=1, element 0) in the cycle after E when the FIFO was empty.
- Flow control:
  - m_valid may only drop after the last beat of the last held row.
  - m_data and the tags are held stable while m_valid & ~m_ready.
- Simultaneous push and final pop when not full: occupancy is unchanged and both pointers advance.
- Tags: m_last_col and m_last_map are combinational from col, the map-row counter and m_valid. Both are 0 when m_valid=0.
- row_ready = (occupancy < DEPTH).
- Widths: col is clog2(ROW_LEN) bits; the map-row counter is clog2(ROWS_PER_MAP) bits. No arithmetic is performed on the data itself.

Decomposition:
- Shared package/defines: DATA_WIDTH, ROW_LEN=13, ROWS_PER_MAP=13, and the pooled-row vector type. These are common with the pool stage.
- One natural sub-module, row_fifo_mem:
  - DEPTH x (ROW_LEN*DATA_WIDTH) register array.
  - Write port for the whole row; combinational read of the element selected by rd_ptr/col.
- Pointer, counter and handshake control stays in pool_row_buffer.

Test Plan:
- Single row: after reset, row_in = 1..13, raise row_done and hold it high for 20 cycles, m_ready=1 -> m_valid rises one cycle after the edge; 13 beats with data 1..13; m_last_col only on the beat with data 13; exactly one push (occupancy returns to 0); overflow=0.
- Backpressure: row 10..22 pushed, m_ready toggles 1,0,0,1... -> no duplicated or skipped elements; m_data is stable during stalls; the sequence is exactly 10..22.
- Overflow: m_ready=0, push 5 rows (done edges), DEPTH=4 -> occupancy=4; row_ready=0; overflow=1; draining yields rows 1-4 only.
- Full boundary: FIFO full, 5th done edge lands in the same cycle as the head row's 13th beat transfer -> push is accepted; overflow stays 0; 4 rows remain.
- Map wrap: stream 14 rows -> m_last_map only on the 169th beat; map_done pulses for one cycle; the row counter restarts, so row 14 is tagged as row 0.
- Reset mid-row: assert rst after beat 5 of a row with 2 rows held -> next cycle m_valid=0, occupancy=0; a new push is then sent starting at element 0.
